// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller: routes CPU data accesses to RAM, I/O registers
// or a bus-error response, with per-region wait states and fault status.
// Ports: clk/reset; CPU req/addr/we/wdata -> ready/rdata/err;
// RAM ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata;
// io_q packed I/O register bank; err_clr -> fault/fault_addr.
module mmio_bus_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(32'h0),
   parameter logic [ADDR_W-1:0] RAM_LAST = ADDR_W'(32'h200),
   parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h208),
   parameter int NUM_IO = 2,
   parameter int RAM_WAIT = 1,
   parameter int IO_WAIT = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req,
   input  logic [ADDR_W-1:0]        addr,
   input  logic                     we,
   input  logic [DATA_W-1:0]        wdata,
   output logic                     ready,
   output logic [DATA_W-1:0]        rdata,
   output logic                     err,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_wdata,
   input  logic [DATA_W-1:0]        ram_rdata,
   output logic [NUM_IO*DATA_W-1:0] io_q,
   input  logic                     err_clr,
   output logic                     fault,
   output logic [ADDR_W-1:0]        fault_addr
);

   localparam int IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
   localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);
   localparam logic [3:0] IO_CNT = 4'(IO_WAIT);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic [1:0] {REG_RAM, REG_IO, REG_ERR} region_t;

   state_t state;
   state_t stateNext;
   logic [3:0] cnt;
   logic [3:0] cntNext;
   region_t newRegion;
   region_t accRegion;
   logic [IDX_W-1:0] newIdx;
   logic [IDX_W-1:0] accIdx;
   logic ioHit;
   logic ramHit;
   logic accWe;
   logic accept;
   logic ioWr;
   logic [NUM_IO-1:0][DATA_W-1:0] ioReg;

   assign io_q = ioReg;

   // Region decode of the request; the result is latched on accept
   // alongside the address so the access tag never changes mid-flight.
   always_comb begin
      ioHit = 1'b0;
      newIdx = '0;
      for (int k = 0; k < NUM_IO; k++) begin
         if (addr == IO_BASE + ADDR_W'(4 * k)) begin
            ioHit = 1'b1;
            newIdx = IDX_W'(k);
         end
      end
      // offset compare keeps the window test free of
      // constant-zero bounds when RAM_BASE is 0
      ramHit = (addr - RAM_BASE) <= (RAM_LAST - RAM_BASE);
      if (addr[1:0] != 2'b00) begin
         newRegion = REG_ERR;
      end else if (ramHit) begin
         newRegion = REG_RAM;
      end else if (ioHit) begin
         newRegion = REG_IO;
      end else begin
         newRegion = REG_ERR;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= stateNext;
         cnt <= cntNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext = cnt;
      accept = 1'b0;
      ioWr = 1'b0;
      ready = 1'b0;
      err = 1'b0;
      ram_en = 1'b0;
      ram_we = 1'b0;
      rdata = '0;
      unique case (state)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (newRegion == REG_ERR) begin
                  stateNext = RESP;
               end else begin
                  stateNext = BUSY;
                  cntNext = (newRegion == REG_RAM)
                          ? RAM_CNT : IO_CNT;
               end
            end
         end
         BUSY: begin
            ram_en = (accRegion == REG_RAM);
            if (cnt == 4'd0) begin
               stateNext = RESP;
            end else begin
               cntNext = cnt - 4'd1;
            end
         end
         RESP: begin
            ready = 1'b1;
            ram_en = (accRegion == REG_RAM);
            ram_we = (accRegion == REG_RAM) && accWe;
            err = (accRegion == REG_ERR);
            ioWr = (accRegion == REG_IO) && accWe;
            if (!accWe) begin
               if (accRegion == REG_RAM) begin
                  rdata = ram_rdata;
               end else if (accRegion == REG_IO) begin
                  rdata = ioReg[accIdx];
               end
            end
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_addr <= '0;
         ram_wdata <= '0;
         accWe <= 1'b0;
         accRegion <= REG_RAM;
         accIdx <= '0;
      end else if (accept) begin
         ram_addr <= addr;
         ram_wdata <= wdata;
         accWe <= we;
         accRegion <= newRegion;
         accIdx <= newIdx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ioReg <= '0;
      end else if (ioWr) begin
         ioReg[accIdx] <= ram_wdata;
      end
   end

   // The first fault address is held until cleared; a fault arriving
   // in the same cycle as the clear takes over the status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault <= 1'b0;
         fault_addr <= '0;
      end else if (err) begin
         fault <= 1'b1;
         if (!fault || err_clr) begin
            fault_addr <= ram_addr;
         end
      end else if (err_clr) begin
         fault <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// tb_mmio_bus_controller: directed table plus corner sequences for
// mmio_bus_controller (default build and a longer-wait build).
module tb_mmio_bus_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, req, we, err_clr;
   logic [31:0] addr, wdata, ram_rdata;
   logic ready, err, ram_en, ram_we, fault;
   logic [31:0] rdata, ram_addr, ram_wdata, fault_addr;
   logic [63:0] io_q;

   logic reset3, req3, we3, err_clr3;
   logic [31:0] addr3, wdata3, ram_rdata3;
   logic ready3, err3, ram_en3, ram_we3, fault3;
   logic [31:0] rdata3, ram_addr3, ram_wdata3, fault_addr3;
   logic [63:0] io_q3;

   mmio_bus_controller dut (
      .clk(clk), .reset(reset), .req(req), .addr(addr),
      .we(we), .wdata(wdata), .ready(ready), .rdata(rdata),
      .err(err), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .io_q(io_q), .err_clr(err_clr),
      .fault(fault), .fault_addr(fault_addr)
   );

   mmio_bus_controller #(.RAM_WAIT(3), .IO_WAIT(2)) dut3 (
      .clk(clk), .reset(reset3), .req(req3), .addr(addr3),
      .we(we3), .wdata(wdata3), .ready(ready3), .rdata(rdata3),
      .err(err3), .ram_en(ram_en3), .ram_we(ram_we3),
      .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
      .ram_rdata(ram_rdata3), .io_q(io_q3), .err_clr(err_clr3),
      .fault(fault3), .fault_addr(fault_addr3)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
      logic [31:0] rr;
      logic        clr;
      int          lat;
      logic        e;
      logic [31:0] rd;
      int          en;
      int          weN;
      logic        f;
      logic [31:0] fa;
      logic [63:0] io;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic access(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [31:0] rr,
                         input logic clr, output int lat,
                         output logic e, output logic [31:0] rd,
                         output int enCnt, output int weCnt,
                         output logic post);
      addr = a; we = w; wdata = d; ram_rdata = rr; req = 1'b1;
      lat = -1; e = 1'b0; rd = '0; enCnt = 0; weCnt = 0;
      post = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         req = 1'b0;
         if (ram_en) enCnt++;
         if (ram_we) weCnt++;
         if (ready) begin
            lat = c; e = err; rd = rdata;
            err_clr = clr;
            @(posedge clk); #1;
            err_clr = 1'b0;
            post = ready;
            if (ram_en) enCnt++;
            if (ram_we) weCnt++;
            break;
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int lat, enCnt, weCnt, n;
      logic e, post;
      logic [31:0] rd;
      logic [15:0] weMask, rdyMask;

      tbl[0]  = '{32'h0,   0, 32'h0,        32'hCAFE0001, 0,
                  3, 0, 32'hCAFE0001, 3, 0, 0, 32'h0,
                  64'h0};
      tbl[1]  = '{32'h208, 1, 32'h1234,     32'h0,        0,
                  2, 0, 32'h0,        0, 0, 0, 32'h0,
                  64'h0000_0000_0000_1234};
      tbl[2]  = '{32'h208, 0, 32'h0,        32'h0,        0,
                  2, 0, 32'h1234,     0, 0, 0, 32'h0,
                  64'h0000_0000_0000_1234};
      tbl[3]  = '{32'h20C, 1, 32'hAAAA5555, 32'h0,        0,
                  2, 0, 32'h0,        0, 0, 0, 32'h0,
                  64'hAAAA_5555_0000_1234};
      tbl[4]  = '{32'h20C, 0, 32'h0,        32'hFFFFFFFF, 0,
                  2, 0, 32'hAAAA5555, 0, 0, 0, 32'h0,
                  64'hAAAA_5555_0000_1234};
      tbl[5]  = '{32'h10,  1, 32'hDEADBEEF, 32'h0,        0,
                  3, 0, 32'h0,        3, 1, 0, 32'h0,
                  64'hAAAA_5555_0000_1234};
      tbl[6]  = '{32'h300, 0, 32'h0,        32'h12345678, 0,
                  1, 1, 32'h0,        0, 0, 1, 32'h300,
                  64'hAAAA_5555_0000_1234};
      tbl[7]  = '{32'h201, 1, 32'hBAD,      32'h12345678, 0,
                  1, 1, 32'h0,        0, 0, 1, 32'h300,
                  64'hAAAA_5555_0000_1234};
      tbl[8]  = '{32'h204, 0, 32'h0,        32'h12345678, 0,
                  1, 1, 32'h0,        0, 0, 1, 32'h300,
                  64'hAAAA_5555_0000_1234};
      tbl[9]  = '{32'h200, 0, 32'h0,        32'h55,       0,
                  3, 0, 32'h55,       3, 0, 1, 32'h300,
                  64'hAAAA_5555_0000_1234};
      tbl[10] = '{32'h210, 1, 32'h777,      32'h12345678, 0,
                  1, 1, 32'h0,        0, 0, 1, 32'h300,
                  64'hAAAA_5555_0000_1234};
      tbl[11] = '{32'h20A, 0, 32'h0,        32'h12345678, 1,
                  1, 1, 32'h0,        0, 0, 1, 32'h20A,
                  64'hAAAA_5555_0000_1234};

      reset = 1'b1; req = 1'b0; we = 1'b0; err_clr = 1'b0;
      addr = '0; wdata = '0; ram_rdata = '0;
      reset3 = 1'b1; req3 = 1'b0; we3 = 1'b0; err_clr3 = 1'b0;
      addr3 = '0; wdata3 = '0; ram_rdata3 = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0; reset3 = 1'b0;

      chk("rst ready", 64'(ready), 64'h0);
      chk("rst err", 64'(err), 64'h0);
      chk("rst rdata", 64'(rdata), 64'h0);
      chk("rst ram_en", 64'(ram_en), 64'h0);
      chk("rst ram_we", 64'(ram_we), 64'h0);
      chk("rst ram_addr", 64'(ram_addr), 64'h0);
      chk("rst ram_wdata", 64'(ram_wdata), 64'h0);
      chk("rst io_q", io_q, 64'h0);
      chk("rst fault", 64'(fault), 64'h0);
      chk("rst fault_addr", 64'(fault_addr), 64'h0);

      for (int i = 0; i < 12; i++) begin
         access(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].rr,
                tbl[i].clr, lat, e, rd, enCnt, weCnt, post);
         chk($sformatf("r%0d lat", i), 64'(lat), 64'(tbl[i].lat));
         chk($sformatf("r%0d err", i), 64'(e), 64'(tbl[i].e));
         chk($sformatf("r%0d rdata", i), 64'(rd), 64'(tbl[i].rd));
         chk($sformatf("r%0d ram_en", i), 64'(enCnt),
             64'(tbl[i].en));
         chk($sformatf("r%0d ram_we", i), 64'(weCnt),
             64'(tbl[i].weN));
         chk($sformatf("r%0d post", i), 64'(post), 64'h0);
         chk($sformatf("r%0d fault", i), 64'(fault),
             64'(tbl[i].f));
         chk($sformatf("r%0d fault_addr", i), 64'(fault_addr),
             64'(tbl[i].fa));
         chk($sformatf("r%0d io_q", i), io_q, tbl[i].io);
      end

      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("clr fault", 64'(fault), 64'h0);
      chk("clr fault_addr", 64'(fault_addr), 64'h20A);
      chk("hold ram_addr", 64'(ram_addr), 64'h20A);

      addr3 = 32'h200; we3 = 1'b1; wdata3 = 32'h99; req3 = 1'b1;
      weMask = '0; rdyMask = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 1) req3 = 1'b0;
         if (ram_we3) weMask[c] = 1'b1;
         if (ready3) rdyMask[c] = 1'b1;
         if (c == 2) begin
            req3 = 1'b1; addr3 = 32'h20C; wdata3 = 32'h4242;
         end
         if (c == 5) req3 = 1'b0;
      end
      chk("w3 ram_we mask", 64'(weMask), 64'h0020);
      chk("w3 ready mask", 64'(rdyMask), 64'h0020);
      chk("w3 ram_addr", 64'(ram_addr3), 64'h200);
      chk("w3 ram_wdata", 64'(ram_wdata3), 64'h99);
      chk("w3 io_q", io_q3, 64'h0);

      addr3 = 32'h20C; we3 = 1'b1; wdata3 = 32'h5151; req3 = 1'b1;
      @(posedge clk); #1;
      req3 = 1'b0;
      @(posedge clk); #1;
      reset3 = 1'b1;
      #2;
      chk("abort ready", 64'(ready3), 64'h0);
      @(posedge clk); #1;
      reset3 = 1'b0;
      n = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         if (ready3) n++;
      end
      chk("abort no ready", 64'(n), 64'h0);
      chk("abort io_q", io_q3, 64'h0);
      chk("abort ram_addr", 64'(ram_addr3), 64'h0);

      addr3 = 32'h20C; we3 = 1'b1; wdata3 = 32'h6161; req3 = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         req3 = 1'b0;
         if (ready3) begin
            lat = c;
            break;
         end
      end
      chk("after lat", 64'(lat), 64'h4);
      @(posedge clk); #1;
      chk("after io_q", io_q3, 64'h0000_6161_0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
